// File: rtl/icache_pkg.sv
// +----------------------------------------------------------------------+
// | icache_pkg : shared sizes, derived widths and FSM encoding for icache |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

package icache_pkg;

  localparam int WORD_SIZE  = 16;
  localparam int LINE_WORDS = 4;
  localparam int NUM_LINES  = 4;

  // LINE_WORDS and NUM_LINES are powers of two, at least 2
  function automatic int offset_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_bits(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_bits(input int word_size, input int line_words, input int num_lines);
    return word_size - $clog2(line_words) - $clog2(num_lines);
  endfunction

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/icache_tag_array.sv
// +----------------------------------------------------------------------+
// | icache_tag_array : valid/tag storage with combinational lookup       |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module icache_tag_array #(
  parameter int NUM_LINES  = 4,
  parameter int INDEX_BITS = 2,
  parameter int TAG_BITS   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_flush,
  input  logic [INDEX_BITS-1:0] i_lookup_index,
  input  logic [TAG_BITS-1:0]   i_lookup_tag,
  output logic                  o_hit,
  input  logic                  i_wr_en,
  input  logic [INDEX_BITS-1:0] i_wr_index,
  input  logic [TAG_BITS-1:0]   i_wr_tag
);

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_BITS-1:0]  r_tag [NUM_LINES];

  // Flush clears first so a refill completing in the same cycle stays valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      if (i_flush) begin
        r_valid <= '0;
      end
      if (i_wr_en) begin
        r_valid[i_wr_index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_index] <= i_wr_tag;
    end
  end

  assign o_hit = r_valid[i_lookup_index] && (r_tag[i_lookup_index] == i_lookup_tag);

endmodule

`default_nettype wire

// File: rtl/icache.sv
// +----------------------------------------------------------------------+
// | icache   : direct-mapped read-only instruction cache, line refill    |
// |            via mem_read/mem_valid; ICACHE_STATS_EN adds counters     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module icache
  import icache_pkg::*;
#(
  parameter int WORD_SIZE  = icache_pkg::WORD_SIZE,
  parameter int LINE_WORDS = icache_pkg::LINE_WORDS,
  parameter int NUM_LINES  = icache_pkg::NUM_LINES
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           cpu_read,
  input  logic [WORD_SIZE-1:0]           cpu_addr,
  output logic [WORD_SIZE-1:0]           cpu_rdata,
  output logic                           cpu_ready,
  input  logic                           flush,
  output logic                           mem_read,
  output logic [WORD_SIZE-1:0]           mem_addr,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] mem_rdata,
  input  logic                           mem_valid,
  output logic [WORD_SIZE-1:0]           num_hit,
  output logic [WORD_SIZE-1:0]           num_miss
);

  localparam int c_offset_bits = offset_bits(LINE_WORDS);
  localparam int c_index_bits  = index_bits(NUM_LINES);
  localparam int c_tag_bits    = tag_bits(WORD_SIZE, LINE_WORDS, NUM_LINES);
  localparam int c_line_bits   = WORD_SIZE * LINE_WORDS;

  state_t                   r_state;
  state_t                   w_next_state;
  logic                     r_mem_read;
  logic [WORD_SIZE-1:0]     r_mem_addr;
  logic [c_line_bits-1:0]   r_data [NUM_LINES];

  logic [c_offset_bits-1:0] w_offset;
  logic [c_index_bits-1:0]  w_index;
  logic [c_tag_bits-1:0]    w_tag;
  logic [c_index_bits-1:0]  w_fill_index;
  logic [c_tag_bits-1:0]    w_fill_tag;
  logic [c_line_bits-1:0]   w_line;
  logic [WORD_SIZE-1:0]     w_words [LINE_WORDS];
  logic                     w_lookup_hit;
  logic                     w_miss;
  logic                     w_fill;

  assign w_offset     = cpu_addr[c_offset_bits-1:0];
  assign w_index      = cpu_addr[c_offset_bits +: c_index_bits];
  assign w_tag        = cpu_addr[WORD_SIZE-1 -: c_tag_bits];
  assign w_fill_index = r_mem_addr[c_offset_bits +: c_index_bits];
  assign w_fill_tag   = r_mem_addr[WORD_SIZE-1 -: c_tag_bits];
  assign w_line       = r_data[w_index];

  for (genvar i = 0; i < LINE_WORDS; i++) begin : g_word
    assign w_words[i] = w_line[i*WORD_SIZE +: WORD_SIZE];
  end

  icache_tag_array #(
    .NUM_LINES  (NUM_LINES),
    .INDEX_BITS (c_index_bits),
    .TAG_BITS   (c_tag_bits)
  ) u_tag_array (
    .clk            (Clk),
    .rst            (Reset),
    .i_flush        (flush),
    .i_lookup_index (w_index),
    .i_lookup_tag   (w_tag),
    .o_hit          (w_lookup_hit),
    .i_wr_en        (w_fill),
    .i_wr_index     (w_fill_index),
    .i_wr_tag       (w_fill_tag)
  );

  always_comb begin
    w_next_state = r_state;
    cpu_ready    = 1'b0;
    cpu_rdata    = '0;
    w_miss       = 1'b0;
    w_fill       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!cpu_read) begin
          cpu_ready = 1'b1;
        end else if (w_lookup_hit && !flush) begin
          cpu_ready = 1'b1;
          cpu_rdata = w_words[w_offset];
        end else begin
          // A flush in this cycle invalidates the line, so treat it as a miss
          w_miss       = 1'b1;
          w_next_state = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (mem_valid) begin
          w_fill       = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_mem_read <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_state    <= w_next_state;
      r_mem_read <= (w_next_state == ST_REFILL);
      if (w_miss) begin
        r_mem_addr <= {cpu_addr[WORD_SIZE-1:c_offset_bits], {c_offset_bits{1'b0}}};
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (w_fill) begin
      r_data[w_fill_index] <= mem_rdata;
    end
  end

  assign mem_read = r_mem_read;
  assign mem_addr = r_mem_addr;

`ifdef ICACHE_STATS_EN
  logic [WORD_SIZE-1:0] r_num_hit;
  logic [WORD_SIZE-1:0] r_num_miss;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_num_hit  <= '0;
      r_num_miss <= '0;
    end else begin
      if ((r_state == ST_IDLE) && cpu_read && cpu_ready) begin
        r_num_hit <= r_num_hit + {{(WORD_SIZE-1){1'b0}}, 1'b1};
      end
      if (w_miss) begin
        r_num_miss <= r_num_miss + {{(WORD_SIZE-1){1'b0}}, 1'b1};
      end
    end
  end

  assign num_hit  = r_num_hit;
  assign num_miss = r_num_miss;
`else
  assign num_hit  = '0;
  assign num_miss = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// +----------------------------------------------------------------------+
// | tb_icache : directed self-checking bench for icache, memory L=3      |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_icache;

  localparam int L = 3;
`ifdef ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic        cpu_read;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic        flush;
  logic        mem_read;
  logic [15:0] mem_addr;
  logic [63:0] mem_rdata;
  logic        mem_valid;
  logic [15:0] num_hit;
  logic [15:0] num_miss;

  int errors = 0;
  int checks = 0;
  int exp_hit = 0;
  int exp_miss = 0;

  icache dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .cpu_read  (cpu_read),
    .cpu_addr  (cpu_addr),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .flush     (flush),
    .mem_read  (mem_read),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .num_hit   (num_hit),
    .num_miss  (num_miss)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_num_hit"},  {48'd0, num_hit},  STATS ? 64'(exp_hit)  : 64'd0);
    check({tag, "_num_miss"}, {48'd0, num_miss}, STATS ? 64'(exp_miss) : 64'd0);
  endtask

  // Present addr and play memory with latency L until the CPU is served.
  task automatic run_fetch(input string tag, input logic [15:0] addr, input logic [63:0] line,
                           input bit flush_on_valid, input bit counts_miss, input int exp_stalls,
                           input logic [15:0] exp_maddr, input logic [15:0] exp_data);
    int stalls = 0;
    int rd = 0;
    bit done = 1'b0;
    logic [15:0] seen_addr = 16'hxxxx;
    @(negedge Clk);
    cpu_addr = addr;
    cpu_read = 1'b1;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc > 0) @(negedge Clk);
      mem_valid = 1'b0;
      flush = 1'b0;
      if (mem_read) begin
        rd++;
        seen_addr = mem_addr;
        if (rd == L + 1) begin
          mem_rdata = line;
          mem_valid = 1'b1;
          flush = flush_on_valid;
        end
      end
      #1;
      if (cpu_ready) done = 1'b1;
      else stalls++;
    end
    check({tag, "_served"}, {63'd0, done}, 64'd1);
    check({tag, "_stalls"}, 64'(stalls), 64'(exp_stalls));
    check({tag, "_mem_addr"}, {48'd0, seen_addr}, {48'd0, exp_maddr});
    check({tag, "_rdata"}, {48'd0, cpu_rdata}, {48'd0, exp_data});
    if (counts_miss) exp_miss++;
    check_counters(tag);
    exp_hit++;
  endtask

  task automatic hit_step(input string tag, input logic [15:0] addr, input logic [15:0] exp_data);
    @(negedge Clk);
    cpu_addr = addr;
    cpu_read = 1'b1;
    #1;
    check({tag, "_ready"}, {63'd0, cpu_ready}, 64'd1);
    check({tag, "_rdata"}, {48'd0, cpu_rdata}, {48'd0, exp_data});
    exp_hit++;
  endtask

  task automatic quiet_step(input string tag);
    @(negedge Clk);
    cpu_read = 1'b0;
    flush = 1'b0;
    #1;
    check_counters(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    cpu_read = 1'b0;
    cpu_addr = 16'h0000;
    flush = 1'b0;
    mem_rdata = 64'd0;
    mem_valid = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    #1;
    check("rst_ready", {63'd0, cpu_ready}, 64'd1);
    check("rst_rdata", {48'd0, cpu_rdata}, 64'd0);
    check("rst_mem_read", {63'd0, mem_read}, 64'd0);
    check("rst_mem_addr", {48'd0, mem_addr}, 64'd0);
    check_counters("rst");
    Reset = 1'b0;

    // Cold miss: L+2 = 5 stall cycles, word 1 of the line
    run_fetch("cold", 16'h0005, 64'h4444_3333_2222_1111, 1'b0, 1'b1, 5, 16'h0004, 16'h2222);

    // Spatial hits in the same line
    hit_step("sp0", 16'h0004, 16'h1111);
    hit_step("sp2", 16'h0006, 16'h3333);
    hit_step("sp3", 16'h0007, 16'h4444);
    quiet_step("spatial");

    // Conflict on index 1, then the evicted line misses again
    run_fetch("conf14", 16'h0014, 64'h8888_7777_6666_5555, 1'b0, 1'b1, 5, 16'h0014, 16'h5555);
    run_fetch("conf04", 16'h0004, 64'h4444_3333_2222_1111, 1'b0, 1'b1, 5, 16'h0004, 16'h1111);
    quiet_step("conflict");

    // One-cycle flush while idle, then a previously valid line misses
    @(negedge Clk);
    cpu_read = 1'b0;
    flush = 1'b1;
    run_fetch("flush04", 16'h0004, 64'h4444_3333_2222_1111, 1'b0, 1'b1, 5, 16'h0004, 16'h1111);

    // Flush with a hitting fetch turns it into a miss in that very cycle
    @(negedge Clk);
    cpu_addr = 16'h0006;
    cpu_read = 1'b1;
    flush = 1'b1;
    #1;
    check("flush_force_ready", {63'd0, cpu_ready}, 64'd0);
    exp_miss++;
    run_fetch("flush06", 16'h0006, 64'h4444_3333_2222_1111, 1'b0, 1'b0, 4, 16'h0004, 16'h3333);

    // Flush coinciding with mem_valid: refilled line still becomes valid
    run_fetch("flushv", 16'h0024, 64'hCCCC_BBBB_AAAA_9999, 1'b1, 1'b1, 5, 16'h0024, 16'h9999);
    hit_step("flushv_hit", 16'h0027, 16'hCCCC);
    quiet_step("flushv");

    // Reset in the middle of a refill
    @(negedge Clk);
    cpu_addr = 16'h0008;
    cpu_read = 1'b1;
    @(negedge Clk);
    #1;
    check("mid_mem_read", {63'd0, mem_read}, 64'd1);
    Reset = 1'b1;
    cpu_read = 1'b0;
    exp_hit = 0;
    exp_miss = 0;
    #1;
    check("mid_rst_mem_read", {63'd0, mem_read}, 64'd0);
    check("mid_rst_ready", {63'd0, cpu_ready}, 64'd1);
    check_counters("mid_rst");
    @(negedge Clk);
    Reset = 1'b0;
    mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    mem_valid = 1'b1;
    @(negedge Clk);
    mem_valid = 1'b0;
    #1;
    check("stale_mem_read", {63'd0, mem_read}, 64'd0);
    run_fetch("post_rst", 16'h0008, 64'h0BB3_0BB2_0BB1_0BB0, 1'b0, 1'b1, 5, 16'h0008, 16'h0BB0);
    quiet_step("post_rst");

    // Idle cycles leave everything quiet
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      cpu_read = 1'b0;
      #1;
      check("idle_ready", {63'd0, cpu_ready}, 64'd1);
      check("idle_mem_read", {63'd0, mem_read}, 64'd0);
    end
    check_counters("idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
